tcdm_responder: RTL

- TCDM slave-side memory model that answers the HWPE TCDM master ports: the load ports of the operand source streamers and the store port of the result sink streamer.
- Word-interleaved, multi-bank, single-cycle-grant memory with round-robin arbitration per bank and fixed read/write response latency.
- Serves as the cluster-L1 stand-in for HWPE integration testbenches, and as a simple shared scratchpad in standalone configurations.

---
 rtl/tcdm_responder_pkg.sv | 37 +++
 rtl/tcdm_responder_if.sv | 25 ++
 rtl/tcdm_responder_rr_arbiter.sv | 43 ++++
 rtl/tcdm_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tcdm_responder_pkg.sv
// tcdm_responder shared types and address-decode helpers.
// Imported by the interface, the arbiter and the top.
package tcdm_responder_package;

   localparam int unsigned BE_WIDTH = 4;
   localparam int unsigned ADDR_LSB = 2;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } resp_entry_t;

   // word index; address bits above the memory size are dropped
   function automatic logic [31:0] word_of(
      input logic [31:0] add,
      input int unsigned word_bits
   );
      return (add >> ADDR_LSB) & ((32'd1 << word_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] bank_of(
      input logic [31:0] add,
      input int unsigned word_bits,
      input int unsigned bank_bits
   );
      return word_of(add, word_bits) & ((32'd1 << bank_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] row_of(
      input logic [31:0] add,
      input int unsigned word_bits,
      input int unsigned bank_bits
   );
      return word_of(add, word_bits) >> bank_bits;
   endfunction

endpackage

// File: rtl/tcdm_responder_if.sv
// TCDM port bundle: request side driven by the master,
// grant and response side driven by the slave.
interface hwpe_stream_intf_tcdm;
   import tcdm_responder_package::*;

   logic                req;
   logic                gnt;
   logic [31:0]         add;
   logic                wen;
   logic [BE_WIDTH-1:0] be;
   logic [31:0]         data;
   logic [31:0]         r_data;
   logic                r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/tcdm_responder_rr_arbiter.sv
// Round-robin arbiter with one-hot priority pointer.
// Pointer moves past the winner only on granting cycles.
module tcdm_responder_rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   logic [N-1:0] ptr_q;
   logic [N-1:0] ptr_d;
   logic [N-1:0] hi;
   logic [N-1:0] pick;
   logic [N-1:0] rot;

   // lowest requester at/after the pointer, else lowest overall
   always_comb begin
      hi    = req_i & ~(ptr_q - N'(1));
      pick  = (|hi) ? hi : req_i;
      gnt_o = pick & (~pick + N'(1)) & {N{en_i}};
      rot   = (gnt_o << 1) | (gnt_o >> (N - 1));
      ptr_d = ptr_q;
      if (clear_i) begin
         ptr_d = N'(1);
      end else if (|gnt_o) begin
         ptr_d = rot;
      end
   end

   // priority pointer register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= N'(1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/tcdm_responder.sv
// Multi-bank word-interleaved TCDM memory model with per-bank arbitration.
// Define TCDM_RESPONDER_STALL_EN for LFSR-driven random grant stalls.
module tcdm_responder
   import tcdm_responder_package::*;
#(
   parameter int unsigned NB_PORTS   = 3,
   parameter int unsigned NB_BANKS   = 4,
   parameter int unsigned MEM_WORDS  = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   hwpe_stream_intf_tcdm.slave tcdm [NB_PORTS],
   output logic [NB_PORTS-1:0] conflict_o
);

   localparam int unsigned WORD_BITS = $clog2(MEM_WORDS);
   localparam int unsigned BANK_BITS = $clog2(NB_BANKS);
   localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int unsigned ROWS      = MEM_WORDS / NB_BANKS;
   localparam int unsigned ROW_BITS  = $clog2(ROWS);
   localparam int unsigned ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;

   logic [NB_PORTS-1:0]   p_req;
   logic [NB_PORTS-1:0]   p_wen;
   logic [NB_PORTS-1:0]   p_gnt;
   logic [BE_WIDTH-1:0]   p_be   [NB_PORTS];
   logic [31:0]           p_data [NB_PORTS];
   logic [BANK_W-1:0]     p_bank [NB_PORTS];
   logic [ROW_W-1:0]      p_row  [NB_PORTS];
   logic [DATA_WIDTH-1:0] rd     [NB_PORTS];

   logic [NB_PORTS-1:0]   bank_req [NB_BANKS];
   logic [NB_PORTS-1:0]   bank_gnt [NB_BANKS];
   logic [NB_BANKS-1:0]   w_en;
   logic [ROW_W-1:0]      w_row  [NB_BANKS];
   logic [DATA_WIDTH-1:0] w_data [NB_BANKS];
   logic [BE_WIDTH-1:0]   w_be   [NB_BANKS];

   logic [DATA_WIDTH-1:0] mem [NB_BANKS][ROWS];
   resp_entry_t           pipe_q [NB_PORTS][LATENCY];

   logic stall;
   logic grant_en;

`ifdef TCDM_RESPONDER_STALL_EN
   logic [15:0] lfsr_q;
   logic        fb;

   assign fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign stall = (lfsr_q[2:0] == 3'b000);

   // free-running stall pattern generator
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= 16'hACE1;
      end else if (clear_i) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], fb};
      end
   end
`else
   assign stall = 1'b0;
`endif

   assign grant_en = ~clear_i & ~stall;

   for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
      assign p_req[p]  = tcdm[p].req;
      assign p_wen[p]  = tcdm[p].wen;
      assign p_be[p]   = tcdm[p].be;
      assign p_data[p] = tcdm[p].data;
      assign p_bank[p] = BANK_W'(bank_of(tcdm[p].add, WORD_BITS, BANK_BITS));
      assign p_row[p]  = ROW_W'(row_of(tcdm[p].add, WORD_BITS, BANK_BITS));

      assign tcdm[p].gnt     = p_gnt[p];
      assign tcdm[p].r_valid = pipe_q[p][LATENCY-1].valid;
      assign tcdm[p].r_data  = pipe_q[p][LATENCY-1].data;
   end

   // route each request to the arbiter of its bank
   always_comb begin
      for (int b = 0; b < NB_BANKS; b++) begin
         bank_req[b] = '0;
         for (int p = 0; p < NB_PORTS; p++) begin
            bank_req[b][p] = p_req[p] && (p_bank[p] == BANK_W'(b));
         end
      end
   end

   for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
      tcdm_responder_rr_arbiter #(
         .N (NB_PORTS)
      ) i_arb (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .clear_i (clear_i),
         .en_i    (grant_en),
         .req_i   (bank_req[b]),
         .gnt_o   (bank_gnt[b])
      );
   end

   // merge per-bank grants back to ports
   always_comb begin
      p_gnt = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         p_gnt = p_gnt | bank_gnt[b];
      end
      conflict_o = p_req & ~p_gnt;
   end

   // select the write winner of each bank
   always_comb begin
      for (int b = 0; b < NB_BANKS; b++) begin
         w_en[b]   = 1'b0;
         w_row[b]  = '0;
         w_data[b] = '0;
         w_be[b]   = '0;
         for (int p = 0; p < NB_PORTS; p++) begin
            if (bank_gnt[b][p] && !p_wen[p]) begin
               w_en[b]   = 1'b1;
               w_row[b]  = p_row[p];
               w_data[b] = p_data[p];
               w_be[b]   = p_be[p];
            end
         end
      end
   end

   // asynchronous read of the addressed word for each port
   always_comb begin
      for (int p = 0; p < NB_PORTS; p++) begin
         rd[p] = mem[p_bank[p]][p_row[p]];
      end
   end

   // byte-enabled bank writes; contents survive reset
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB_BANKS; b++) begin
         if (w_en[b]) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
               if (w_be[b][i]) begin
                  mem[b][w_row[b]][8*i +: 8] <= w_data[b][8*i +: 8];
               end
            end
         end
      end
   end

   // fixed-latency response shift register per port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < NB_PORTS; p++) begin
            for (int s = 0; s < LATENCY; s++) begin
               pipe_q[p][s] <= '0;
            end
         end
      end else if (clear_i) begin
         for (int p = 0; p < NB_PORTS; p++) begin
            for (int s = 0; s < LATENCY; s++) begin
               pipe_q[p][s] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < NB_PORTS; p++) begin
            pipe_q[p][0].valid <= p_gnt[p];
            pipe_q[p][0].data  <= (p_gnt[p] && p_wen[p]) ? rd[p] : 32'h0;
            for (int s = 1; s < LATENCY; s++) begin
               pipe_q[p][s] <= pipe_q[p][s-1];
            end
         end
      end
   end

endmodule
